orv64_fetch_resp_mux: RTL and testbench
=======================================

// Module: orv64_fetch_resp_mux
// PURPOSE
//  Sits between IF and the {inst trace buffer, icache} pair. Probes the trace buffer with every
//  IF fetch. On a hit, returns the buffered line. On a miss, forwards the request to the icache
//  and tracks the single outstanding miss. Merges both response sources into one registered
//  response to IF. Handles flush-kill of in-flight misses and keeps hit/miss/timeout statistics.
// PARAMETERS
//  CNT_W      32    width of saturating hit/miss counters
//  TIMEOUT    1024  WAIT_IC cycles before fm_timeout is raised (>=2)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  reset, asynchronous, active-high
//  if2fm        in   orv64_if2ic_t      IF fetch request (.en, .pc)
//  fm_stall     out  1                  IF must hold/not issue if2fm this cycle
//  fm2if        out  orv64_ic2if_t      merged response to IF (registered)
//  itb_hit      in   1                  trace buffer same-cycle hit for if2fm.pc
//  itb_hit_ff   in   1                  trace buffer hit, delayed 1 cycle
//  itb2fm       in   orv64_ic2if_t      trace buffer data, valid with itb_hit_ff
//  fm2ic        out  orv64_if2ic_t      miss request to icache
//  ic_req_rdy   in   1                  icache accepts fm2ic this cycle
//  ic2fm        in   orv64_ic2if_t      icache response (.valid)
//  fm_flush     in   1                  kill all in-flight fetches (redirect)
//  fm_hit_cnt   out  CNT_W              saturating count of ITB-served fetches
//  fm_miss_cnt  out  CNT_W              saturating count of icache-accepted misses
//  fm_timeout   out  1                  sticky: WAIT_IC exceeded TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; fm2if='0; fm2ic='0; counters 0; fm_timeout 0; hit_pend 0; wait_cnt 0.
//  FSM states IDLE, REQ, WAIT_IC, DRAIN.
//  IDLE:
//   - flush: no action; clear hit_pend.
//   - en & itb_hit: set hit_pend, fm_hit_cnt++.
//   - en & ~itb_hit: fm2ic={en=1,pc}, same cycle.
//       ic_req_rdy -> WAIT_IC, latch pc, fm_miss_cnt++.
//       else -> REQ.
//   - fm_stall=0.
//  REQ: fm2ic={en=1,latched pc}, fm_stall=1.
//   - ic_req_rdy -> WAIT_IC, fm_miss_cnt++.
//   - flush -> IDLE, nothing issued.
//  WAIT_IC: fm2ic.en=0, fm_stall=1, wait_cnt++.
//   - ic2fm.valid & ~flush -> IDLE; next cycle fm2if=ic2fm.
//   - ic2fm.valid & flush -> IDLE; response dropped.
//   - flush & ~ic2fm.valid -> DRAIN.
//  DRAIN: fm_stall=1.
//   - ic2fm.valid -> IDLE; response dropped, fm2if.valid=0.
//   - flush while in DRAIN: stay DRAIN.
//  Hit path: hit_pend & itb_hit_ff & ~flush -> fm2if<=itb2fm next edge. Total ITB latency 2 from en.
//   Flush in the itb_hit_ff cycle drops the data.
//  Miss latency: fm2if.valid one cycle after ic2fm.valid.
//  fm2if<='0 in every cycle with no qualified source; at most one source per cycle by construction.
//  Back-to-back hits: en with itb_hit each cycle -> one fm2if per cycle, pipelined.
//  wait_cnt clears on WAIT_IC entry. wait_cnt==TIMEOUT sets fm_timeout; it clears only on rst.
//  Counters saturate at all-ones; no wrap.
//  rst asserted mid-miss: return to reset values. A late ic2fm.valid after reset is ignored in IDLE.
//  ic2fm.valid seen in IDLE or REQ is ignored and not forwarded.
//  fm_flush has priority over if2fm.en in the same cycle: no request, no count.
// TESTING
//  1. Hit: en, pc=0x1000, itb_hit=1; next cycle itb_hit_ff=1 -> fm2if=itb2fm at cycle+2,
//     fm_hit_cnt=1, fm2ic.en never 1.
//  2. Miss, ready: pc=0x2000, itb_hit=0, ic_req_rdy=1; ic2fm.valid 5 cycles later ->
//     fm2if=ic2fm next cycle, fm_stall=1 for 5 cycles, fm_miss_cnt=1.
//  3. Backpressure: ic_req_rdy=0 for 3 cycles -> fm2ic.pc held at 0x2000 in REQ,
//     accepted on cycle 4, fm_miss_cnt=1.
//  4. Flush mid-miss: flush 2 cycles into WAIT_IC, ic2fm.valid 3 cycles later -> DRAIN,
//     fm2if.valid stays 0, IDLE after the drop.
//  5. Simultaneous ic2fm.valid & flush in WAIT_IC -> IDLE, no fm2if.valid.
//     Flush & en same cycle in IDLE -> no fm2ic.en, no count.
//  6. TIMEOUT=8, no ic2fm.valid -> fm_timeout=1 after 8 WAIT_IC cycles, stays 1.
//     Async rst mid-wait -> all outputs 0 immediately.

Source files
------------

// File: rtl/orv64_fetch_resp_mux.sv
// Fetch response mux: probes the inst trace buffer, forwards misses to the icache,
// merges both response sources into one registered response to IF, tracks one outstanding miss.
module orv64_fetch_resp_mux #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned PC_W    = 40,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if2fm_en,
  input  logic [PC_W-1:0]   if2fm_pc,
  output logic              fm_stall,
  output logic              fm2if_valid,
  output logic [DATA_W-1:0] fm2if_data,
  input  logic              itb_hit,
  input  logic              itb_hit_ff,
  input  logic              itb2fm_valid,
  input  logic [DATA_W-1:0] itb2fm_data,
  output logic              fm2ic_en,
  output logic [PC_W-1:0]   fm2ic_pc,
  input  logic              ic_req_rdy,
  input  logic              ic2fm_valid,
  input  logic [DATA_W-1:0] ic2fm_data,
  input  logic              fm_flush,
  output logic [CNT_W-1:0]  fm_hit_cnt,
  output logic [CNT_W-1:0]  fm_miss_cnt,
  output logic              fm_timeout
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_IC, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              hit_pend_q, hit_pend_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              fm2if_valid_q, fm2if_valid_d;
  logic [DATA_W-1:0] fm2if_data_q, fm2if_data_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              timeout_q, timeout_d;
  logic              hit_inc, miss_inc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hit_pend_d    = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    fm2if_valid_d = 1'b0;
    fm2if_data_d  = '0;
    fm2ic_en      = 1'b0;
    fm2ic_pc      = '0;
    fm_stall      = 1'b1;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    // A hit probed last cycle delivers regardless of where the miss FSM sits.
    if (hit_pend_q && itb_hit_ff && !fm_flush) begin
      fm2if_valid_d = itb2fm_valid;
      fm2if_data_d  = itb2fm_data;
    end

    case (state_q)
      IDLE: begin
        fm_stall = 1'b0;
        if (!fm_flush && if2fm_en) begin
          if (itb_hit) begin
            hit_pend_d = 1'b1;
            hit_inc    = 1'b1;
          end else begin
            fm2ic_en = 1'b1;
            fm2ic_pc = if2fm_pc;
            pc_d     = if2fm_pc;
            if (ic_req_rdy) begin
              state_d    = WAIT_IC;
              wait_cnt_d = '0;
              miss_inc   = 1'b1;
            end else begin
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        if (fm_flush) begin
          state_d = IDLE;
        end else begin
          fm2ic_en = 1'b1;
          fm2ic_pc = pc_q;
          if (ic_req_rdy) begin
            state_d    = WAIT_IC;
            wait_cnt_d = '0;
            miss_inc   = 1'b1;
          end
        end
      end
      WAIT_IC: begin
        wait_cnt_d = (wait_cnt_q == WC_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
        if (wait_cnt_d == WC_W'(TIMEOUT)) timeout_d = 1'b1;
        if (ic2fm_valid) begin
          state_d = IDLE;
          if (!fm_flush) begin
            fm2if_valid_d = 1'b1;
            fm2if_data_d  = ic2fm_data;
          end
        end else if (fm_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ic2fm_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    hit_cnt_d  = (hit_inc && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      hit_pend_q    <= 1'b0;
      wait_cnt_q    <= '0;
      fm2if_valid_q <= 1'b0;
      fm2if_data_q  <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hit_pend_q    <= hit_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      fm2if_valid_q <= fm2if_valid_d;
      fm2if_data_q  <= fm2if_data_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign fm2if_valid = fm2if_valid_q;
  assign fm2if_data  = fm2if_data_q;
  assign fm_hit_cnt  = hit_cnt_q;
  assign fm_miss_cnt = miss_cnt_q;
  assign fm_timeout  = timeout_q;

endmodule

// File: tb/tb_orv64_fetch_resp_mux.sv
// Directed bench for orv64_fetch_resp_mux: transaction-level model checked every cycle
// plus hand-computed literal expectations for the key scenarios.
module tb_orv64_fetch_resp_mux;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned PC_W    = 40;
  localparam int unsigned DATA_W  = 64;
  localparam int          CMAX    = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if2fm_en = 1'b0;
  logic [PC_W-1:0]   if2fm_pc = '0;
  logic              fm_stall;
  logic              fm2if_valid;
  logic [DATA_W-1:0] fm2if_data;
  logic              itb_hit = 1'b0;
  logic              itb_hit_ff = 1'b0;
  logic              itb2fm_valid = 1'b0;
  logic [DATA_W-1:0] itb2fm_data = '0;
  logic              fm2ic_en;
  logic [PC_W-1:0]   fm2ic_pc;
  logic              ic_req_rdy = 1'b0;
  logic              ic2fm_valid = 1'b0;
  logic [DATA_W-1:0] ic2fm_data = '0;
  logic              fm_flush = 1'b0;
  logic [CNT_W-1:0]  fm_hit_cnt;
  logic [CNT_W-1:0]  fm_miss_cnt;
  logic              fm_timeout;

  orv64_fetch_resp_mux #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .if2fm_en(if2fm_en), .if2fm_pc(if2fm_pc), .fm_stall(fm_stall),
    .fm2if_valid(fm2if_valid), .fm2if_data(fm2if_data), .itb_hit(itb_hit),
    .itb_hit_ff(itb_hit_ff), .itb2fm_valid(itb2fm_valid), .itb2fm_data(itb2fm_data),
    .fm2ic_en(fm2ic_en), .fm2ic_pc(fm2ic_pc), .ic_req_rdy(ic_req_rdy),
    .ic2fm_valid(ic2fm_valid), .ic2fm_data(ic2fm_data), .fm_flush(fm_flush),
    .fm_hit_cnt(fm_hit_cnt), .fm_miss_cnt(fm_miss_cnt), .fm_timeout(fm_timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: one optional outstanding miss record plus a one-deep hit pipe.
  bit              m_hit_pipe, m_live, m_acc, m_killed, m_tmo, m_out_v;
  logic [PC_W-1:0] m_pc;
  logic [63:0]     m_out_d;
  int              m_age, m_hits, m_misses;
  bit              nv;
  logic [63:0]     nd;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hit_pipe = 0; m_live = 0; m_acc = 0; m_killed = 0; m_tmo = 0;
      m_out_v = 0; m_out_d = '0; m_pc = '0; m_age = 0; m_hits = 0; m_misses = 0;
    end else begin
      nv = 0; nd = '0;
      if (m_hit_pipe && itb_hit_ff && !fm_flush) begin nv = itb2fm_valid; nd = itb2fm_data; end
      m_hit_pipe = 0;
      if (!m_live) begin
        if (!fm_flush && if2fm_en) begin
          if (itb_hit) begin
            m_hit_pipe = 1;
            if (m_hits < CMAX) m_hits++;
          end else begin
            m_live = 1; m_pc = if2fm_pc; m_killed = 0; m_acc = ic_req_rdy; m_age = 0;
            if (ic_req_rdy && m_misses < CMAX) m_misses++;
          end
        end
      end else if (!m_acc) begin
        if (fm_flush) m_live = 0;
        else if (ic_req_rdy) begin
          m_acc = 1; m_age = 0;
          if (m_misses < CMAX) m_misses++;
        end
      end else begin
        if (!m_killed) begin
          m_age++;
          if (m_age == TIMEOUT) m_tmo = 1;
        end
        if (ic2fm_valid) begin
          m_live = 0;
          if (!m_killed && !fm_flush) begin nv = 1; nd = ic2fm_data; end
        end else if (fm_flush) m_killed = 1;
      end
      m_out_v = nv; m_out_d = nd;
    end
  end

  bit              e_ic_en;
  logic [PC_W-1:0] e_ic_pc;

  initial forever begin
    @(negedge clk);
    if (!rst && chk_on) begin
      e_ic_en = !fm_flush && (m_live ? !m_acc : (if2fm_en && !itb_hit));
      e_ic_pc = e_ic_en ? (m_live ? m_pc : if2fm_pc) : '0;
      chk("fm2if_valid", 64'(fm2if_valid), 64'(m_out_v));
      chk("fm2if_data", fm2if_data, m_out_d);
      chk("fm_stall", 64'(fm_stall), 64'(m_live));
      chk("fm2ic_en", 64'(fm2ic_en), 64'(e_ic_en));
      chk("fm2ic_pc", 64'(fm2ic_pc), 64'(e_ic_pc));
      chk("fm_hit_cnt", 64'(fm_hit_cnt), 64'(m_hits));
      chk("fm_miss_cnt", 64'(fm_miss_cnt), 64'(m_misses));
      chk("fm_timeout", 64'(fm_timeout), 64'(m_tmo));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fm2if_valid"}, 64'(fm2if_valid), 64'd0);
    chk({tag, "_fm2if_data"}, fm2if_data, 64'd0);
    chk({tag, "_fm2ic_en"}, 64'(fm2ic_en), 64'd0);
    chk({tag, "_fm_stall"}, 64'(fm_stall), 64'd0);
    chk({tag, "_hit_cnt"}, 64'(fm_hit_cnt), 64'd0);
    chk({tag, "_miss_cnt"}, 64'(fm_miss_cnt), 64'd0);
    chk({tag, "_timeout"}, 64'(fm_timeout), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int stalls;

  initial begin
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    step(); step();
    rst = 1'b0;
    chk_on = 1'b1;
    step();

    // 1. single hit, data two edges after en
    if2fm_en = 1; if2fm_pc = 40'h1000; itb_hit = 1;
    step();
    if2fm_en = 0; itb_hit = 0; itb_hit_ff = 1; itb2fm_valid = 1; itb2fm_data = 64'hAAAA_0001;
    step();
    itb_hit_ff = 0; itb2fm_valid = 0;
    chk("hit_valid", 64'(fm2if_valid), 64'd1);
    chk("hit_data", fm2if_data, 64'hAAAA_0001);
    chk("hit_cnt1", 64'(fm_hit_cnt), 64'd1);
    step();

    // 2. miss accepted immediately, response 5 cycles later
    if2fm_en = 1; if2fm_pc = 40'h2000; ic_req_rdy = 1;
    #1;
    chk("miss_req_en", 64'(fm2ic_en), 64'd1);
    chk("miss_req_pc", 64'(fm2ic_pc), 64'h2000);
    step();
    if2fm_en = 0; ic_req_rdy = 0;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      if (fm_stall) stalls++;
      if (i == 4) begin ic2fm_valid = 1; ic2fm_data = 64'hBBBB_0002; end
      step();
    end
    ic2fm_valid = 0;
    chk("miss_stall_cycles", 64'(stalls), 64'd5);
    chk("miss_valid", 64'(fm2if_valid), 64'd1);
    chk("miss_data", fm2if_data, 64'hBBBB_0002);
    chk("miss_cnt1", 64'(fm_miss_cnt), 64'd1);
    chk("miss_unstall", 64'(fm_stall), 64'd0);
    step();

    // ic response while idle is not forwarded
    ic2fm_valid = 1; ic2fm_data = 64'hDEAD;
    step();
    ic2fm_valid = 0;
    chk("idle_resp_ignored", 64'(fm2if_valid), 64'd0);

    // 3. backpressure: three not-ready cycles, accepted on the fourth
    if2fm_en = 1; if2fm_pc = 40'h2000;
    step();
    if2fm_en = 0; if2fm_pc = 40'h5555;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("req_hold_en", 64'(fm2ic_en), 64'd1);
      chk("req_hold_pc", 64'(fm2ic_pc), 64'h2000);
      step();
    end
    ic_req_rdy = 1;
    step();
    ic_req_rdy = 0;
    chk("bp_miss_cnt", 64'(fm_miss_cnt), 64'd2);
    ic2fm_valid = 1; ic2fm_data = 64'hCCCC_0003;
    step();
    ic2fm_valid = 0;
    chk("bp_resp", fm2if_data, 64'hCCCC_0003);
    step();

    // 4. flush mid-miss, extra flush in DRAIN, late response dropped
    if2fm_en = 1; if2fm_pc = 40'h3000; ic_req_rdy = 1;
    step();
    if2fm_en = 0; ic_req_rdy = 0;
    step();
    fm_flush = 1;
    step();
    fm_flush = 0;
    step();
    fm_flush = 1;
    step();
    fm_flush = 0; ic2fm_valid = 1; ic2fm_data = 64'hEEEE_0004;
    #1 chk("drain_stall", 64'(fm_stall), 64'd1);
    step();
    ic2fm_valid = 0;
    chk("drain_drop", 64'(fm2if_valid), 64'd0);
    chk("drain_idle", 64'(fm_stall), 64'd0);
    step();

    // 5. response and flush together; then flush beats en in idle
    if2fm_en = 1; if2fm_pc = 40'h4000; ic_req_rdy = 1;
    step();
    if2fm_en = 0; ic_req_rdy = 0; ic2fm_valid = 1; ic2fm_data = 64'h1234; fm_flush = 1;
    step();
    ic2fm_valid = 0; fm_flush = 0;
    chk("flush_resp_drop", 64'(fm2if_valid), 64'd0);
    chk("flush_resp_idle", 64'(fm_stall), 64'd0);
    if2fm_en = 1; if2fm_pc = 40'h4100; fm_flush = 1; ic_req_rdy = 1;
    #1 chk("flush_en_noreq", 64'(fm2ic_en), 64'd0);
    step();
    itb_hit = 1;
    step();
    if2fm_en = 0; itb_hit = 0; fm_flush = 0; ic_req_rdy = 0;
    chk("flush_en_miss_cnt", 64'(fm_miss_cnt), 64'd4);
    chk("flush_en_hit_cnt", 64'(fm_hit_cnt), 64'd1);

    // hit whose delayed cycle coincides with a flush is dropped
    if2fm_en = 1; if2fm_pc = 40'h1100; itb_hit = 1;
    step();
    if2fm_en = 0; itb_hit = 0; itb_hit_ff = 1; itb2fm_valid = 1; itb2fm_data = 64'h77; fm_flush = 1;
    step();
    itb_hit_ff = 0; itb2fm_valid = 0; fm_flush = 0;
    chk("hit_flush_drop", 64'(fm2if_valid), 64'd0);
    chk("hit_cnt2", 64'(fm_hit_cnt), 64'd2);

    // back-to-back hits, one response per cycle, hit counter saturates
    for (int i = 0; i <= 20; i++) begin
      if2fm_en = (i < 20); itb_hit = (i < 20); if2fm_pc = 40'h8000 + 40'(i * 8);
      itb_hit_ff = (i > 0); itb2fm_valid = (i > 0); itb2fm_data = 64'hF000 + 64'(i);
      step();
      if (i > 0) chk("b2b_data", fm2if_data, 64'hF000 + 64'(i));
    end
    if2fm_en = 0; itb_hit = 0; itb_hit_ff = 0; itb2fm_valid = 0;
    chk("hit_cnt_sat", 64'(fm_hit_cnt), 64'd15);
    step();

    // 6. timeout after TIMEOUT waiting cycles, sticky, then async reset mid-wait
    if2fm_en = 1; if2fm_pc = 40'h6000; ic_req_rdy = 1;
    step();
    if2fm_en = 0; ic_req_rdy = 0;
    repeat (TIMEOUT - 1) step();
    chk("timeout_not_yet", 64'(fm_timeout), 64'd0);
    step();
    chk("timeout_set", 64'(fm_timeout), 64'd1);
    repeat (3) step();
    chk("timeout_sticky", 64'(fm_timeout), 64'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    step();
    rst = 1'b0;
    ic2fm_valid = 1; ic2fm_data = 64'h9999;
    step();
    ic2fm_valid = 0;
    chk("late_resp_ignored", 64'(fm2if_valid), 64'd0);
    step(); step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
